// File: rtl/inverter_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// inverter_arbiter_pkg
//   Shared types and constants for the inverter_arbiter slice.
//   - rsp_state_e : occupancy of the single output register (EMPTY / FULL)
//   - STAT_W      : width of the completed-transaction counter
//   - STAT_MAX    : saturation value of that counter
//   - sat_inc()   : saturating increment used by the optional statistics
// -----------------------------------------------------------------------------
package inverter_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  localparam int unsigned        STAT_W   = 16;
  localparam logic [STAT_W-1:0]  STAT_MAX = '1;

  // Add one unless already at the top of the range.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == STAT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/inverter_arbiter_inv_stage.sv
// -----------------------------------------------------------------------------
// inv_stage
//   DATA_W-wide register with load enable that captures the bitwise inverse of
//   its input. Cleared by a synchronous active-high reset.
//
//   Ports:
//     clk   in   clock, rising edge
//     rst   in   synchronous active-high reset (clears q)
//     load  in   capture ~d on the next rising edge
//     d     in   DATA_W data to invert
//     q     out  registered inverse, held while load is low
// -----------------------------------------------------------------------------
module inv_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // NOTE: state is updated with non-blocking (<=) assignments so every
  // register samples its inputs from before the edge, independent of the
  // order in which always blocks are evaluated.
  // NOTE: the data register is reset on purpose: the result is observable on
  // rsp_data and must read zero after reset, not leftover data.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= ~d;
    end
  end

endmodule

// File: rtl/inverter_arbiter.sv
// -----------------------------------------------------------------------------
// inverter_arbiter
//   NUM_REQ requesters share one registered inversion stage. A round-robin
//   arbiter picks one valid requester per accept; its data is inverted and
//   registered, and presented one cycle later with the winner's index.
//   The output register is a one-entry buffer (EMPTY/FULL) with a
//   valid/ready handshake towards the consumer.
//
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   synchronous active-high reset
//     req_valid   in   [NUM_REQ]        per-requester valid
//     req_data    in   [NUM_REQ*DATA_W] requester i at [i*DATA_W +: DATA_W]
//     req_ready   out  [NUM_REQ]        one-hot grant, combinational
//     rsp_valid   out  result held on rsp_data
//     rsp_data    out  [DATA_W]         ~(accepted request data)
//     rsp_id      out  [$clog2(NUM_REQ)] index of the producing requester
//     rsp_ready   in   consumer takes the result when rsp_valid && rsp_ready
//     stat_count  out  [16] completed-transaction count
//
//   Configuration macro:
//     INVERTER_ARBITER_STATS_EN  when defined, stat_count counts completed
//                                handshakes and saturates at 16'hFFFF; when
//                                undefined, stat_count is tied to zero.
// -----------------------------------------------------------------------------
module inverter_arbiter
  import inverter_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  input  logic                        rsp_ready,
  output logic [STAT_W-1:0]           stat_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  rsp_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   grant_idx;
  logic              found;
  logic              acc;
  logic [DATA_W-1:0] sel_data;

  // (base + offset) mod NUM_REQ; NUM_REQ need not be a power of two, so the
  // wrap is explicit rather than relying on ID_W-bit overflow.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int              offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return ID_W'(sum);
  endfunction

  // Round-robin search: first valid requester at or above ptr_q, wrapping.
  // NOTE: every variable driven here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[wrap_add(ptr_q, k)]) begin
        found     = 1'b1;
        grant_idx = wrap_add(ptr_q, k);
      end
    end
  end

  // Accept only when the output register is free or being drained this
  // cycle; reset blocks any accept so no handshake completes under rst.
  assign rsp_valid = (state_q == FULL);
  assign acc       = found && (!rsp_valid || rsp_ready) && !rst;
  assign req_ready = acc ? (NUM_REQ'(1) << grant_idx) : '0;
  assign sel_data  = req_data[grant_idx*DATA_W +: DATA_W];

  // Output-register occupancy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (acc) state_d = FULL;
      FULL:  begin
        if (acc)            state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      rsp_id  <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        ptr_q  <= wrap_add(grant_idx, 1);
        rsp_id <= grant_idx;
      end
    end
  end

  inv_stage #(
    .DATA_W (DATA_W)
  ) u_inv_stage (
    .clk  (clk),
    .rst  (rst),
    .load (acc),
    .d    (sel_data),
    .q    (rsp_data)
  );

`ifdef INVERTER_ARBITER_STATS_EN
  logic [STAT_W-1:0] stat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else if (rsp_valid && rsp_ready) begin
      stat_q <= sat_inc(stat_q);
    end
  end

  assign stat_count = stat_q;
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_inverter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inverter_arbiter
//   Directed bench for inverter_arbiter (NUM_REQ=4, DATA_W=8). A reference
//   model tracks pointer, occupancy and completions; accepted requests push
//   their expected result onto a scoreboard queue which is compared against
//   rsp_data/rsp_id while the result is held and popped on handshake.
// -----------------------------------------------------------------------------
module tb_inverter_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        id;
  } rsp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [1:0]                rsp_id;
  logic                      rsp_ready;
  logic [15:0]               stat_count;

  inverter_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  rsp_t        sb[$];
  logic        m_valid = 1'b0;
  logic [1:0]  m_ptr   = '0;
  logic [15:0] m_count = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_stat();
`ifdef INVERTER_ARBITER_STATS_EN
    return m_count;
`else
    return 16'h0000;
`endif
  endfunction

  // One clock cycle: compare at the falling edge, advance the model, then
  // return 1 time unit after the rising edge so the caller can drive inputs.
  task automatic cycle();
    logic [NUM_REQ-1:0] exp_rr;
    logic               m_acc;
    logic [1:0]         gidx;
    logic [1:0]         cand;
    rsp_t               item;
    @(negedge clk);
    exp_rr = '0;
    m_acc  = 1'b0;
    gidx   = '0;
    if (!rst && (|req_valid) && (!m_valid || rsp_ready)) begin
      m_acc = 1'b1;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = m_ptr + 2'(k);
        if (req_valid[cand]) gidx = cand;
      end
      exp_rr[gidx] = 1'b1;
    end
    check("req_ready",  32'(req_ready),  32'(exp_rr));
    check("rsp_valid",  32'(rsp_valid),  32'(m_valid));
    check("stat_count", 32'(stat_count), 32'(exp_stat()));
    if (m_valid) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
        check("rsp_id",   32'(rsp_id),   32'(sb[0].id));
      end
    end
    if (rst) begin
      sb.delete();
      m_valid = 1'b0;
      m_ptr   = '0;
      m_count = '0;
    end else begin
      if (m_valid && rsp_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        if (m_count != 16'hFFFF) m_count = m_count + 1'b1;
      end
      if (m_acc) begin
        item.data = ~req_data[gidx*DATA_W +: DATA_W];
        item.id   = gidx;
        sb.push_back(item);
        m_ptr   = gidx + 2'd1;
        m_valid = 1'b1;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    req_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    cycle();
    rst       = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b0;

    // Reset with requests pending: no grants, outputs cleared.
    cycle();
    cycle();
    check("reset_rsp_valid",  32'(rsp_valid),  32'd0);
    check("reset_rsp_data",   32'(rsp_data),   32'd0);
    check("reset_rsp_id",     32'(rsp_id),     32'd0);
    check("reset_stat_count", 32'(stat_count), 32'd0);
    rst = 1'b0;
    req_valid = '0;

    // Test 1: single request 8'h5A from requester 0.
    req_valid = 4'b0001;
    req_data  = {8'h11, 8'h22, 8'h33, 8'h5A};
    rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data",  32'(rsp_data),  32'hA5);
    check("t1_rsp_id",    32'(rsp_id),    32'd0);
    cycle();

    // Test 2: all requesters valid from ptr=0 -> grants 0,1,2,3,0.
    do_reset();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      rand_data();
      #1;
      check("t2_grant", 32'(req_ready), 32'(4'b0001 << (n % 4)));
      cycle();
    end

    // Test 3: hold FULL for 5 cycles with requests pending, then release.
    rsp_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      rand_data();
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();
    check("t3_single_completion", 32'(rsp_valid), 32'd0);
    cycle();

    // Test 4: move ptr to 3 via requester 2, then 4'b1001 -> 3 then 0.
    do_reset();
    req_valid = 4'b0100;
    rand_data();
    cycle();
    req_valid = '0;
    cycle();
    req_valid = 4'b1001;
    rand_data();
    #1;
    check("t4_grant_3", 32'(req_ready), 32'(4'b1000));
    cycle();
    rand_data();
    #1;
    check("t4_grant_0", 32'(req_ready), 32'(4'b0001));
    cycle();
    req_valid = '0;
    cycle();

    // Test 5: reset while FULL discards the result and clears ptr.
    req_valid = 4'b0100;
    rand_data();
    cycle();
    rsp_ready = 1'b0;
    req_valid = '0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    rsp_ready = 1'b1;
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 4'b1111;
    rand_data();
    #1;
    check("t5_ptr_zero", 32'(req_ready), 32'(4'b0001));
    cycle();
    req_valid = '0;
    cycle();

    // Test 6: exactly 10 completions from a clean start.
    do_reset();
    for (int n = 0; n < 10; n++) begin
      req_valid = 4'(1 << (n % 4));
      rand_data();
      cycle();
    end
    req_valid = '0;
    cycle();
    cycle();
`ifdef INVERTER_ARBITER_STATS_EN
    check("t6_stat_count", 32'(stat_count), 32'd10);
`else
    check("t6_stat_count", 32'(stat_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inverter_arbiter.md
INVERTER_ARBITER -- requirements
Module: inverter_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing the registered inversion stage (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_W, default 8: data width of each request and of the result.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: bit i high means requester i presents data.
REQ-006 The block SHALL have port req_data, input, NUM_REQ*DATA_W bits: requester i data at bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot grant; bit i high means requester i's data is accepted this cycle.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: a result is held on rsp_data.
REQ-009 The block SHALL have port rsp_data, output, DATA_W bits: bitwise inverse of the accepted request data.
REQ-010 The block SHALL have port rsp_id, output, $clog2(NUM_REQ) bits: index of the requester that produced rsp_data.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result when rsp_valid and rsp_ready are both high.
REQ-012 The block SHALL have port stat_count, output, 16 bits: completed-transaction count (see Configuration).

Function
REQ-013 The block SHALL accept a request in a cycle iff |req_valid and (!rsp_valid or rsp_ready); call this acc.
REQ-014 req_ready SHALL be combinational, zero when acc is low, and have exactly one bit set (the winner) when acc is high.
REQ-015 The winner SHALL be the first set req_valid bit searched upward from pointer ptr, wrapping NUM_REQ-1 to 0.
REQ-016 On accept of requester i, ptr SHALL become (i+1) mod NUM_REQ; with no accept, ptr SHALL be unchanged.
REQ-017 Output-register states SHALL be EMPTY (rsp_valid=0) and FULL (rsp_valid=1), with these transitions:
- EMPTY to FULL on acc.
- FULL to FULL on acc with rsp_ready (back-to-back, new data).
- FULL to EMPTY on rsp_ready without acc.
- FULL holds on !rsp_ready.
REQ-018 Latency SHALL be one cycle: data accepted in cycle N appears on rsp_data as ~data, with rsp_id=i, in cycle N+1.
REQ-019 While FULL and rsp_ready is low, rsp_data and rsp_id SHALL remain stable and req_ready SHALL be all zero.
REQ-020 req_data of non-granted requesters SHALL be ignored; requests are never dropped or duplicated.

Reset
REQ-021 While rst is high, req_ready SHALL be 0 and, at the next clock edge, rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0 and stat_count=0.
REQ-022 A reset asserted while FULL SHALL discard the held result; no handshake SHALL complete in a cycle where rst is high.

Configuration
REQ-023 With macro INVERTER_ARBITER_STATS_EN defined, stat_count SHALL increment by 1 on each rsp_valid&&rsp_ready cycle and saturate at 16'hFFFF.
REQ-024 Without INVERTER_ARBITER_STATS_EN, stat_count SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-025 A shared package inverter_arbiter_pkg SHALL hold the FULL/EMPTY state typedef and the stat_count width constant (16).
REQ-026 The registered inversion SHALL be one sub-module, inv_stage (DATA_W-wide register with load enable, output = ~input at load).

Verification (NUM_REQ=4, DATA_W=8)
REQ-027 Test 1: after reset, req_valid=4'b0001, req0=8'h5A, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=8'hA5, rsp_id=0.
REQ-028 Test 2: all four requesters valid continuously with rsp_ready=1 -> grants in order 0,1,2,3,0, one per cycle, rsp_valid held high.
REQ-029 Test 3: FULL with rsp_ready=0 for 5 cycles -> rsp_data and rsp_id stable, req_ready=0, then release -> a single completion only.
REQ-030 Test 4: ptr=3 with req_valid=4'b1001 -> grant to 3, then to 0 (wrap).
REQ-031 Test 5: rst pulsed while FULL -> rsp_valid=0 on the next cycle and ptr=0.
REQ-032 Test 6: with INVERTER_ARBITER_STATS_EN, 10 completions -> stat_count=10; without the macro, stat_count=0.
